// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by an internal word array. Independent read and write
// FSMs share the memory; bursts are INCR with 4-byte beats, up to 16 beats.
`timescale 1ns/1ps

module axi_sram_slave #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h1c00_0000
) (
    input  logic        aclk,
    input  logic        areset,
    // Read address channel
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    // Read data channel
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // Write address channel
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    // Write data channel
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // Write response channel
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int unsigned IdxW     = $clog2(MEM_WORDS);
    localparam logic [31:0] MemBytes = 32'(MEM_WORDS * 4);
    localparam logic [1:0]  RespOkay = 2'b00;
    localparam logic [1:0]  RespSlv  = 2'b10;

    logic [31:0] mem [MEM_WORDS];

    // Offset wraps at 32 bits, so addresses below the base land far out of range.
    function automatic logic in_range(input logic [31:0] addr);
        return (addr - BASE_ADDR) < MemBytes;
    endfunction

    function automatic logic [IdxW-1:0] word_idx(input logic [31:0] addr);
        return IdxW'((addr - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [31:0] beat_data(input logic [31:0] addr);
        return in_range(addr) ? mem[word_idx(addr)] : 32'h0;
    endfunction

    function automatic logic [1:0] beat_resp(input logic [31:0] addr);
        return in_range(addr) ? RespOkay : RespSlv;
    endfunction

    // Sideband fields carry nothing this model needs.
    logic unused_inputs;
    assign unused_inputs = ^{arsize, arburst, arlock, arcache, arprot, arlen[7:4],
                             awsize, awburst, awlock, awcache, awprot, awlen[7:4], wid};

    // ------------------------------------------------------------------ read

    typedef enum logic [1:0] {RBoot, RIdle, RData} r_state_e;

    r_state_e    r_state;
    logic [31:0] r_addr;
    logic [3:0]  r_beat;
    logic [3:0]  r_len;
    logic [31:0] r_next_addr;

    assign r_next_addr = r_addr + 32'd4;

    // Read FSM; rdata is fetched one beat ahead so it holds steady under stall.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= RBoot;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= 4'h0;
            rdata   <= 32'h0;
            rresp   <= RespOkay;
            r_addr  <= 32'h0;
            r_beat  <= 4'h0;
            r_len   <= 4'h0;
        end else begin
            case (r_state)
                RBoot: begin
                    arready <= 1'b1;
                    r_state <= RIdle;
                end
                RIdle: begin
                    if (arvalid) begin
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rid     <= arid;
                        r_addr  <= araddr;
                        r_len   <= arlen[3:0];
                        r_beat  <= 4'h0;
                        rdata   <= beat_data(araddr);
                        rresp   <= beat_resp(araddr);
                        rlast   <= (arlen[3:0] == 4'h0);
                        r_state <= RData;
                    end
                end
                RData: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            rdata   <= 32'h0;
                            rresp   <= RespOkay;
                            arready <= 1'b1;
                            r_state <= RIdle;
                        end else begin
                            r_addr <= r_next_addr;
                            r_beat <= r_beat + 4'd1;
                            rdata  <= beat_data(r_next_addr);
                            rresp  <= beat_resp(r_next_addr);
                            rlast  <= ((r_beat + 4'd1) == r_len);
                        end
                    end
                end
                default: r_state <= RBoot;
            endcase
        end
    end

    // ----------------------------------------------------------------- write

    typedef enum logic [1:0] {WBoot, WIdle, WData, WResp} w_state_e;

    w_state_e    w_state;
    logic [31:0] w_addr;
    logic [3:0]  w_beat;
    logic [3:0]  w_len;
    logic [3:0]  w_id;
    logic        w_err;
    logic        w_fire;
    logic        w_hit;
    logic        w_is_last;
    logic        beat_err;

    assign w_fire    = (w_state == WData) && wvalid;
    assign w_hit     = in_range(w_addr);
    assign w_is_last = (w_beat == w_len);
    assign beat_err  = !w_hit || (wlast != w_is_last);

    // Write FSM; the beat count alone ends the burst, wlast only feeds the error flag.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= WBoot;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= 4'h0;
            bresp   <= RespOkay;
            w_addr  <= 32'h0;
            w_beat  <= 4'h0;
            w_len   <= 4'h0;
            w_id    <= 4'h0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                WBoot: begin
                    awready <= 1'b1;
                    w_state <= WIdle;
                end
                WIdle: begin
                    if (awvalid) begin
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_id    <= awid;
                        w_addr  <= awaddr;
                        w_len   <= awlen[3:0];
                        w_beat  <= 4'h0;
                        w_err   <= 1'b0;
                        w_state <= WData;
                    end
                end
                WData: begin
                    if (w_fire) begin
                        w_addr <= w_addr + 32'd4;
                        w_beat <= w_beat + 4'd1;
                        if (beat_err) begin
                            w_err <= 1'b1;
                        end
                        if (w_is_last) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= w_id;
                            bresp   <= (w_err || beat_err) ? RespSlv : RespOkay;
                            w_state <= WResp;
                        end
                    end
                end
                WResp: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        bresp   <= RespOkay;
                        awready <= 1'b1;
                        w_state <= WIdle;
                    end
                end
                default: w_state <= WBoot;
            endcase
        end
    end

    // Byte-masked store; out-of-range beats are dropped. Not reset.
    always_ff @(posedge aclk) begin
        if (w_fire && w_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: behavioural memory model plus
// expected-beat queues checked every cycle the R/B channels are valid.
`timescale 1ns/1ps

module tb_axi_sram_slave;

    localparam int unsigned MemWords = 1024;
    localparam logic [31:0] Base     = 32'h1c00_0000;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;

    axi_sram_slave #(
        .MEM_WORDS(MemWords),
        .BASE_ADDR(Base)
    ) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(3'd2), .arburst(2'b01),
        .arlock(2'b00), .arcache(4'h0), .arprot(3'h0), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(3'd2), .awburst(2'b01),
        .awlock(2'b00), .awcache(4'h0), .awprot(3'h0), .awvalid(awvalid), .awready(awready),
        .wid(4'h0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial forever #5 aclk = ~aclk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rbeat_t      rq[$];
    bexp_t       bq[$];
    logic [31:0] model_mem [MemWords];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    int          checks = 0;
    int          failures = 0;
    bit          rr_toggle = 1'b0;

    logic [31:0] last_rdata;
    logic [3:0]  last_rid;
    logic [1:0]  last_rresp;
    logic        last_rlast;
    logic [3:0]  last_bid;
    logic [1:0]  last_bresp;

    function automatic bit m_in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - Base;
        return off < MemWords * 4;
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - Base) >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Master-side read ready: always accepting, or alternating to exercise stalls.
    initial forever begin
        @(posedge aclk);
        #1;
        rready = rr_toggle ? ~rready : 1'b1;
    end

    // Compare process: every cycle R or B is valid, it must match the queue head.
    initial forever begin
        @(negedge aclk);
        if (!areset) begin
            if (rvalid) begin
                if (rq.size() == 0) begin
                    chk("r_unexpected", {31'b0, rvalid}, 32'h0);
                end else begin
                    chk("rid", {28'b0, rid}, {28'b0, rq[0].id});
                    chk("rdata", rdata, rq[0].data);
                    chk("rresp", {30'b0, rresp}, {30'b0, rq[0].resp});
                    chk("rlast", {31'b0, rlast}, {31'b0, rq[0].last});
                    if (rready) begin
                        last_rdata = rdata;
                        last_rid   = rid;
                        last_rresp = rresp;
                        last_rlast = rlast;
                        void'(rq.pop_front());
                    end
                end
            end
            if (bvalid) begin
                if (bq.size() == 0) begin
                    chk("b_unexpected", {31'b0, bvalid}, 32'h0);
                end else begin
                    chk("bid", {28'b0, bid}, {28'b0, bq[0].id});
                    chk("bresp", {30'b0, bresp}, {30'b0, bq[0].resp});
                    if (bready) begin
                        last_bid   = bid;
                        last_bresp = bresp;
                        void'(bq.pop_front());
                    end
                end
            end
        end
    end

    task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n;
        int cnt;
        logic [3:0] l4;
        rbeat_t e;
        l4 = len[3:0];
        n = int'(l4) + 1;
        for (int b = 0; b < n; b++) begin
            logic [31:0] a;
            a = addr + 32'(4 * b);
            e.id   = id;
            e.last = (b == n - 1);
            if (m_in_range(a)) begin
                e.data = model_mem[m_idx(a)];
                e.resp = 2'b00;
            end else begin
                e.data = 32'h0;
                e.resp = 2'b10;
            end
            rq.push_back(e);
        end
        @(posedge aclk);
        #1;
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        cnt = 0;
        @(negedge aclk);
        while (!arready && cnt < 50) begin
            @(negedge aclk);
            cnt++;
        end
        chk("ar_accept", {31'b0, arready}, 32'h1);
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_rdone();
        int cnt;
        cnt = 0;
        while (rq.size() != 0 && cnt < 500) begin
            @(posedge aclk);
            cnt++;
        end
        chk("r_done", rq.size(), 32'h0);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input bit bad_wlast);
        bit err;
        int cnt;
        bexp_t e;
        err = bad_wlast;
        for (int b = 0; b <= len; b++) begin
            if (!m_in_range(addr + 32'(4 * b))) err = 1'b1;
        end
        e.id   = id;
        e.resp = err ? 2'b10 : 2'b00;
        bq.push_back(e);
        @(posedge aclk);
        #1;
        awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        cnt = 0;
        @(negedge aclk);
        while (!awready && cnt < 50) begin
            @(negedge aclk);
            cnt++;
        end
        chk("aw_accept", {31'b0, awready}, 32'h1);
        @(posedge aclk);
        #1;
        awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            logic [31:0] a;
            a = addr + 32'(4 * b);
            wvalid = 1'b1;
            wdata  = wd[b];
            wstrb  = ws[b];
            wlast  = (b == len) ^ bad_wlast;
            cnt = 0;
            @(negedge aclk);
            while (!wready && cnt < 50) begin
                @(negedge aclk);
                cnt++;
            end
            chk("w_accept", {31'b0, wready}, 32'h1);
            if (m_in_range(a)) begin
                for (int k = 0; k < 4; k++) begin
                    if (ws[b][k]) model_mem[m_idx(a)][8*k +: 8] = wd[b][8*k +: 8];
                end
            end
            @(posedge aclk);
            #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        cnt = 0;
        while (bq.size() != 0 && cnt < 200) begin
            @(posedge aclk);
            cnt++;
        end
        chk("b_done", bq.size(), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) ws[i] = 4'hf;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_arready", {31'b0, arready}, 32'h0);
        chk("rst_awready", {31'b0, awready}, 32'h0);
        chk("rst_wready", {31'b0, wready}, 32'h0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
        chk("rst_bvalid", {31'b0, bvalid}, 32'h0);
        chk("rst_rlast", {31'b0, rlast}, 32'h0);
        chk("rst_rid_bid", {24'b0, rid, bid}, 32'h0);
        chk("rst_resps", {28'b0, rresp, bresp}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("boot_arready", {31'b0, arready}, 32'h0);
        @(negedge aclk);
        chk("idle_arready", {31'b0, arready}, 32'h1);
        chk("idle_awready", {31'b0, awready}, 32'h1);
        chk("idle_wready", {31'b0, wready}, 32'h0);
        chk("idle_valids", {30'b0, rvalid, bvalid}, 32'h0);

        // Single write then read
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hf;
        do_write(4'd3, Base + 32'h10, 0, 1'b0);
        chk("single_bid", {28'b0, last_bid}, 32'h3);
        chk("single_bresp", {30'b0, last_bresp}, 32'h0);
        issue_ar(4'd5, Base + 32'h10, 8'd0);
        wait_rdone();
        chk("single_rdata", last_rdata, 32'hDEADBEEF);
        chk("single_rid", {28'b0, last_rid}, 32'h5);
        chk("single_rlast", {31'b0, last_rlast}, 32'h1);
        chk("single_rresp", {30'b0, last_rresp}, 32'h0);

        // Byte strobes
        wd[0] = 32'h11223344; ws[0] = 4'h5;
        do_write(4'd3, Base + 32'h10, 0, 1'b0);
        ws[0] = 4'hf;
        chk("strobe_model", model_mem[m_idx(Base + 32'h10)], 32'hDE22BE44);
        issue_ar(4'd5, Base + 32'h10, 8'd0);
        wait_rdone();
        chk("strobe_rdata", last_rdata, 32'hDE22BE44);

        // 4-beat burst, read back with rready toggling
        for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
        do_write(4'd1, Base + 32'h100, 3, 1'b0);
        rr_toggle = 1'b1;
        issue_ar(4'd2, Base + 32'h100, 8'd3);
        wait_rdone();
        rr_toggle = 1'b0;
        chk("burst_last_rdata", last_rdata, 32'h4);
        chk("burst_last_rlast", {31'b0, last_rlast}, 32'h1);

        // Out of range read, and a write crossing the top of memory
        issue_ar(4'd6, Base + 32'h1000, 8'd0);
        wait_rdone();
        chk("oor_rdata", last_rdata, 32'h0);
        chk("oor_rresp", {30'b0, last_rresp}, 32'h2);
        wd[0] = 32'hA5A5A5A5; wd[1] = 32'h5A5A5A5A;
        do_write(4'd7, Base + 32'hffc, 1, 1'b0);
        chk("oor_bresp", {30'b0, last_bresp}, 32'h2);
        chk("oor_model_top", model_mem[MemWords-1], 32'hA5A5A5A5);
        issue_ar(4'd8, Base + 32'hffc, 8'd1);
        wait_rdone();
        chk("oor_partial_rresp", {30'b0, last_rresp}, 32'h2);

        // wlast mismatch still writes but flags SLVERR; arlen truncated to 4 bits
        wd[0] = 32'h111; wd[1] = 32'h222;
        do_write(4'd9, Base + 32'h200, 1, 1'b1);
        chk("wlast_bresp", {30'b0, last_bresp}, 32'h2);
        issue_ar(4'd9, Base + 32'h200, 8'h11);
        wait_rdone();
        chk("trunc_last_rdata", last_rdata, 32'h222);

        // Overlapping read and write bursts on disjoint regions
        for (int i = 0; i < 8; i++) wd[i] = 32'(16 + i);
        do_write(4'd4, Base + 32'h300, 7, 1'b0);
        for (int i = 0; i < 8; i++) wd[i] = 32'(256 + i);
        rr_toggle = 1'b1;
        fork
            begin
                issue_ar(4'd1, Base + 32'h300, 8'd7);
                wait_rdone();
            end
            do_write(4'd2, Base + 32'h400, 7, 1'b0);
        join
        rr_toggle = 1'b0;
        issue_ar(4'd3, Base + 32'h400, 8'd7);
        wait_rdone();
        chk("conc_last_rdata", last_rdata, 32'h107);

        // Reset in the middle of a read burst
        rr_toggle = 1'b1;
        issue_ar(4'd1, Base + 32'h300, 8'd7);
        repeat (2) @(posedge aclk);
        #1;
        chk("pre_rst_rvalid", {31'b0, rvalid}, 32'h1);
        areset = 1'b1;
        #1;
        chk("mid_rst_rvalid", {31'b0, rvalid}, 32'h0);
        chk("mid_rst_arready", {31'b0, arready}, 32'h0);
        rq.delete();
        rr_toggle = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (2) @(posedge aclk);
        issue_ar(4'd5, Base + 32'h10, 8'd0);
        wait_rdone();
        chk("post_rst_rdata", last_rdata, 32'hDE22BE44);
        chk("post_rst_rid", {28'b0, last_rid}, 32'h5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
